dequant_recon_uv: RTL

Decoder-side chroma reconstruction for one macroblock. Takes the 8 quantized 4x4 chroma level blocks (4 U, 4 V) the encoder-side UV reconstruction produces, dequantizes them, runs the VP8 inverse transform, adds prediction and clips. Output is the 8x8 U + 8x8 V reconstructed pixels. Sits after the bitstream/level decode stage, in front of the loop filter and frame store. For identical inputs, the output must be bit-exact with the encoder-side reconstruction.

---
 rtl/dequant_recon_uv_pkg.sv | 57 +++++
 rtl/dequant_recon_uv_idct4x4_core.sv | 70 +++++++
 rtl/dequant_recon_uv.sv | 111 +++++++++++
 3 files changed

// File: rtl/dequant_recon_uv_pkg.sv
// Shared types, constants and arithmetic helpers for the chroma dequant/IDCT/recon path.
package dequant_recon_uv_pkg;

  localparam int BLOCK_SIZE = 8;
  localparam int COEFF_W    = 16;
  localparam int INTER_W    = 20;
  localparam int K1         = 20091;
  localparam int K2         = 35468;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;
  typedef logic signed [INTER_W-1:0] inter_t;

  // Top-left pixel of each 4x4 block inside the 8x16 UV tile (U: cols 0..7, V: cols 8..15).
  localparam logic [3:0] ROW_BASE [0:BLOCK_SIZE-1] = '{4'd0, 4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd4, 4'd4};
  localparam logic [3:0] COL_BASE [0:BLOCK_SIZE-1] = '{4'd0, 4'd4, 4'd0, 4'd4, 4'd8, 4'd12, 4'd8, 4'd12};

  function automatic logic signed [COEFF_W-1:0] dequant(input logic [COEFF_W-1:0] level,
                                                        input logic [15:0] qv);
    logic signed [32:0] prod;
    prod = $signed(level) * $signed({1'b0, qv});
    if (prod > 33'sd32767)       return 16'sh7fff;
    else if (prod < -33'sd32768) return 16'sh8000;
    else                         return prod[COEFF_W-1:0];
  endfunction

  function automatic inter_t m1(input inter_t a);
    logic signed [39:0] p;
    p = 40'(a) * 40'(K1);
    return inter_t'(p >>> 16) + a;
  endfunction

  function automatic inter_t m2(input inter_t a);
    logic signed [39:0] p;
    p = 40'(a) * 40'(K2);
    return inter_t'(p >>> 16);
  endfunction

  // One 4-point inverse transform; output k sits at [INTER_W*k +: INTER_W].
  function automatic logic [4*INTER_W-1:0] butterfly(input inter_t e0, input inter_t e1,
                                                     input inter_t e2, input inter_t e3);
    inter_t a, b, cc, d;
    a  = e0 + e2;
    b  = e0 - e2;
    cc = m2(e1) - m1(e3);
    d  = m1(e1) + m2(e3);
    return {a - d, b - cc, b + cc, a + d};
  endfunction

  function automatic logic [7:0] recon(input logic [7:0] pred, input inter_t x);
    inter_t s;
    s = $signed({12'd0, pred}) + (x >>> 3);
    if (s < 0)               return 8'd0;
    else if (s > 20'sd255)   return 8'd255;
    else                     return s[7:0];
  endfunction

endpackage

// File: rtl/dequant_recon_uv_idct4x4_core.sv
// Two-stage 4x4 core: dequant + vertical pass, then horizontal pass + prediction add + clip.
module idct4x4_core
  import dequant_recon_uv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [2:0]             in_blk,
  input  logic                   in_skip,
  input  logic [16*COEFF_W-1:0]  levels,
  input  logic [127:0]           pred,
  input  logic [31:0]            q,
  output logic                   out_valid,
  output logic [2:0]             out_blk,
  output logic [127:0]           pix
);

  inter_t              c   [16];
  inter_t              t_d [16];
  inter_t              s1_t [16];
  logic [127:0]        s1_pred;
  logic                s1_skip;
  logic [2:0]          s1_blk;
  logic                s1_valid;
  logic [4*INTER_W-1:0] h;
  logic [127:0]        pix_d;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    c   = '{default: '0};
    t_d = '{default: '0};
    for (int j = 0; j < 16; j++)
      c[j] = inter_t'(dequant(levels[16*j +: 16], (j == 0) ? q[15:0] : q[31:16]));
    for (int i = 0; i < 4; i++)
      {t_d[4*i+3], t_d[4*i+2], t_d[4*i+1], t_d[4*i]} = butterfly(c[i], c[4+i], c[8+i], c[12+i]);
  end

  always_comb begin
    h     = '0;
    pix_d = '0;
    for (int i = 0; i < 4; i++) begin
      h = butterfly(s1_t[i] + inter_t'(4), s1_t[4+i], s1_t[8+i], s1_t[12+i]);
      for (int k = 0; k < 4; k++)
        pix_d[8*(4*i+k) +: 8] = recon(s1_pred[8*(4*i+k) +: 8], h[INTER_W*k +: INTER_W]);
    end
    if (s1_skip) pix_d = s1_pred;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    s1_t    <= t_d;
    s1_pred <= pred;
    s1_skip <= in_skip;
    s1_blk  <= in_blk;
    out_blk <= s1_blk;
    pix     <= pix_d;
  end

endmodule

// File: rtl/dequant_recon_uv.sv
// Macroblock sequencer: latches inputs, feeds eight 4x4 blocks to the core, writes UVout back.
module dequant_recon_uv
  import dequant_recon_uv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2047:0] UVlevels,
  input  logic [1023:0] UVPred,
  input  logic [31:0]   q,
  input  logic [31:0]   nz,
  output logic [1023:0] UVout,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [2:0]    blk;
  logic          drain_cnt;
  logic [2047:0] lv_q;
  logic [1023:0] pred_q;
  logic [31:0]   q_q;
  logic [7:0]    nz_q;
  logic [255:0]  blk_levels;
  logic [127:0]  blk_pred;
  logic          out_valid;
  logic [2:0]    out_blk;
  logic [127:0]  out_pix;
  logic          unused_nz;

  assign unused_nz = ^{nz[31:24], nz[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      blk       <= 3'd0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_ISSUE;
          blk   <= 3'd0;
          busy  <= 1'b1;
        end
        ST_ISSUE: if (blk == 3'd7) begin
          state     <= ST_DRAIN;
          drain_cnt <= 1'b0;
        end else begin
          blk <= blk + 3'd1;
        end
        ST_DRAIN: if (drain_cnt) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end else begin
          drain_cnt <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          blk   <= 3'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      lv_q   <= UVlevels;
      pred_q <= UVPred;
      q_q    <= q;
      nz_q   <= nz[23:16];
    end
  end

  always_comb begin
    blk_levels = lv_q[256*blk +: 256];
    blk_pred   = '0;
    for (int r = 0; r < 4; r++)
      for (int cl = 0; cl < 4; cl++)
        blk_pred[8*(4*r+cl) +: 8] = pred_q[8*(16*(ROW_BASE[blk]+r) + COL_BASE[blk] + cl) +: 8];
  end

  idct4x4_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state == ST_ISSUE),
    .in_blk    (blk),
    .in_skip   (~nz_q[blk]),
    .levels    (blk_levels),
    .pred      (blk_pred),
    .q         (q_q),
    .out_valid (out_valid),
    .out_blk   (out_blk),
    .pix       (out_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      UVout <= '0;
    end else if (out_valid) begin
      for (int r = 0; r < 4; r++)
        for (int cl = 0; cl < 4; cl++)
          UVout[8*(16*(ROW_BASE[out_blk]+r) + COL_BASE[out_blk] + cl) +: 8] <= out_pix[8*(4*r+cl) +: 8];
    end
  end

endmodule
